// File: rtl/fmem_arb.sv
// rtl/fmem_arb.sv - two-master arbiter for a single 36-bit fast-memory slave
// One transaction per grant, round-robin or fixed priority, with a stall watchdog.
module fmem_arb #(
  parameter bit          FIXED_PRI = 1'b0,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [17:0] i_m0_address,
  input  logic        i_m0_read,
  input  logic        i_m0_write,
  input  logic [35:0] i_m0_writedata,
  output logic [35:0] o_m0_readdata,
  output logic        o_m0_waitrequest,
  input  logic [17:0] i_m1_address,
  input  logic        i_m1_read,
  input  logic        i_m1_write,
  input  logic [35:0] i_m1_writedata,
  output logic [35:0] o_m1_readdata,
  output logic        o_m1_waitrequest,
  output logic [17:0] o_s_address,
  output logic        o_s_read,
  output logic        o_s_write,
  output logic [35:0] o_s_writedata,
  input  logic [35:0] i_s_readdata,
  input  logic        i_s_waitrequest,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam bit          WD_EN       = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic req0, req1, gnt0, gnt1, gnt_req, wd_fire, done;

  assign req0    = i_m0_read | i_m0_write;
  assign req1    = i_m1_read | i_m1_write;
  assign gnt0    = (state_q == GRANT0);
  assign gnt1    = (state_q == GRANT1);
  assign gnt_req = (gnt0 & req0) | (gnt1 & req1);
  // Forced completion: the master is released with zero data instead of hanging.
  assign wd_fire = WD_EN && gnt_req && i_s_waitrequest && (wd_cnt_q == TIMEOUT_CNT);
  assign done    = gnt_req && (!i_s_waitrequest || wd_fire);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (req0 && (!req1 || FIXED_PRI || last_q))
          state_d = GRANT0;
        else if (req1)
          state_d = GRANT1;
      end
      default: begin
        // A grantee that withdraws its request is dropped without touching last.
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          last_d  = gnt1;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    o_s_address   = '0;
    o_s_read      = 1'b0;
    o_s_write     = 1'b0;
    o_s_writedata = '0;
    if (gnt0) begin
      o_s_address   = i_m0_address;
      o_s_read      = i_m0_read;
      o_s_write     = i_m0_write;
      o_s_writedata = i_m0_writedata;
    end else if (gnt1) begin
      o_s_address   = i_m1_address;
      o_s_read      = i_m1_read;
      o_s_write     = i_m1_write;
      o_s_writedata = i_m1_writedata;
    end
  end

  assign o_m0_waitrequest = gnt0 ? (i_s_waitrequest & ~wd_fire) : 1'b1;
  assign o_m1_waitrequest = gnt1 ? (i_s_waitrequest & ~wd_fire) : 1'b1;
  assign o_m0_readdata    = (gnt0 & ~wd_fire) ? i_s_readdata : '0;
  assign o_m1_readdata    = (gnt1 & ~wd_fire) ? i_s_readdata : '0;
  assign o_timeout        = wd_fire;

endmodule

// File: doc/fmem_arb.md
# fmem_arb

Two-port bus arbiter that shares a single 36-bit, 18-bit-address memory slave, such as fast memory or core, between two masters, for example the processor and the console/IO path. It uses a read/write/waitrequest handshake on all three ports. Grant is held for exactly one transaction, selected round-robin or fixed-priority. A watchdog aborts transactions the slave never completes.

## Interface
- FIXED_PRI, 0: 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.
- TIMEOUT, 256: stalled-cycle limit before abort; 0 disables the watchdog. Counter width is 16 bits, so TIMEOUT ≤ 65535.
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_m0_address / i_m1_address  in  18  master address
- i_m0_read / i_m1_read  in  1  read request
- i_m0_write / i_m1_write  in  1  write request
- i_m0_writedata / i_m1_writedata  in  36  write data
- o_m0_readdata / o_m1_readdata  out  36  read data, valid when the master's waitrequest is 0
- o_m0_waitrequest / o_m1_waitrequest  out  1  stall to master
- o_s_address  out  18  to slave
- o_s_read / o_s_write  out  1  to slave
- o_s_writedata  out  36  to slave
- i_s_readdata  in  36  from slave
- i_s_waitrequest  in  1  from slave
- o_timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- A master requests when read|write = 1. It holds address, data and strobe until its waitrequest = 0. Read and write together are forwarded unchanged; the slave defines the result.
- State machine: IDLE, GRANT0, GRANT1. A `last` register records the most recent grantee.
- IDLE:
  - With no requests, stay in IDLE.
  - With one requester, go to that requester's GRANT state.
  - With both requesting and FIXED_PRI=1, go to GRANT0.
  - With both requesting and FIXED_PRI=0, grant the master not equal to `last`.
- GRANTn:
  - o_s_* is a combinational copy of master n's signals.
  - o_mn_readdata = i_s_readdata; o_mn_waitrequest = i_s_waitrequest.
  - Completion occurs in the first GRANTn cycle with i_s_waitrequest = 0. Set `last` = n, go to IDLE.
  - Abort: if master n drops both strobes while granted, go to IDLE with no completion and leave `last` unchanged.
- The non-granted master, and both masters in IDLE, see waitrequest = 1 and readdata = 0.
- In IDLE, o_s_address, o_s_read, o_s_write and o_s_writedata are all 0.
- Watchdog: a 16-bit counter clears on entering GRANTn and increments each GRANTn cycle with i_s_waitrequest = 1.
  - If TIMEOUT ≠ 0, counter == TIMEOUT and i_s_waitrequest = 1, the cycle is a forced completion.
  - In that cycle o_mn_waitrequest = 0, o_mn_readdata = 0 and o_timeout = 1. Set `last` = n, go to IDLE.
  - Slave strobes remain forwarded during that cycle.
- Reset values, asynchronous: state IDLE, `last` = 1 (m0 wins the first tie), counter 0, o_timeout 0.
  - Combinational outputs follow from IDLE: all o_s_* = 0, both waitrequest = 1, both readdata = 0.
- Reset asserted mid-transaction aborts immediately with no completion to either master.

## Timing
- Arbitration costs one cycle: a request seen in IDLE at edge k is granted from cycle k+1.
- With a zero-wait slave, a transaction takes 2 cycles: arbitrate, then access. Master waitrequest is 0 in the second cycle.
- Each slave wait state adds 1 cycle.
- Back-to-back: after a completion the arbiter passes through IDLE for one cycle. Minimum spacing is 2 cycles per transaction.
- Under continuous requests from both masters with FIXED_PRI=0, grants alternate m0, m1, m0, … and neither master starves.
- With FIXED_PRI=1, m1 starvation under continuous m0 traffic is permitted.
- A watchdog abort ends the transaction TIMEOUT+1 cycles after grant.
- All outputs are combinational from state and inputs. There is no registered data path.

## Test plan
- Zero-wait slave, m0 writes 0o123456701234 at address 0o5, then reads 0o5. Each transaction takes 2 cycles and the read returns 0o123456701234. m1 waitrequest stays 1 throughout.
- Both masters request reads on the same edge after reset, FIXED_PRI=0. m0 is granted first and m1 next; a second tie goes to m0.
- FIXED_PRI=1, m0 and m1 request continuously. m0 wins every arbitration and m1 never completes.
- Slave holds waitrequest for 3 cycles on an m1 write. o_m1_waitrequest is 1 for exactly 4 cycles including arbitration, and o_s_write is held stable.
- TIMEOUT=4, slave waitrequest stuck at 1. o_timeout pulses exactly once, 5 cycles after grant. The master sees waitrequest 0 and readdata 0, and the arbiter returns to IDLE.
- i_reset_n pulsed low while GRANT0 is stalled. Outputs immediately show the reset values, and the next tie goes to m0.
